// File: rtl/bht_pkg.sv
// Shared types and the saturating-counter helper for the branch history table.
package bht_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t SNT = 2'd0;
   localparam cnt_t WNT = 2'd1;
   localparam cnt_t WT  = 2'd2;
   localparam cnt_t ST  = 2'd3;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   function automatic cnt_t sat_next(input cnt_t c, input logic taken);
      cnt_t n;
      if (taken) begin
         n = (c == ST) ? ST : c + 2'd1;
      end else begin
         n = (c == SNT) ? SNT : c - 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bht_controller.sv
// Branch history table of 2-bit saturating counters with one lookup port,
// one training port and an init sequencer run after reset and on flush.
module bht_controller
   import bht_pkg::*;
#(
   parameter int   ENTRIES  = 16,
   parameter int   IDX_W    = $clog2(ENTRIES),
   parameter cnt_t INIT_CNT = WNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   output logic             busy,
   input  logic             pred_valid,
   output logic             pred_ready,
   input  logic [IDX_W-1:0] pred_idx,
   output logic             resp_valid,
   output logic             resp_taken,
   output logic [1:0]       resp_count,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] init_idx_q, init_idx_d;
   cnt_t             bht_q [ENTRIES];
   cnt_t             bht_d [ENTRIES];
   logic             resp_valid_q, resp_valid_d;
   cnt_t             resp_count_q, resp_count_d;

   logic pred_acc_s;
   logic upd_en_s;
   cnt_t upd_next_s;

   assign busy       = (state_q == INIT);
   assign pred_ready = (state_q == RUN);
   assign upd_ready  = (state_q == RUN);
   assign resp_valid = resp_valid_q;
   assign resp_count = resp_count_q;
   assign resp_taken = resp_count_q[1];

   // A flush cycle drops the update: the table is about to be rewritten anyway.
   assign pred_acc_s = pred_valid && pred_ready;
   assign upd_en_s   = upd_valid && upd_ready && !flush;
   assign upd_next_s = sat_next(bht_q[upd_idx], upd_taken);

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      bht_d      = bht_q;
      case (state_q)
         INIT: begin
            bht_d[init_idx_q] = INIT_CNT;
            if (flush) begin
               init_idx_d = '0;
            end else if (init_idx_q == LAST_IDX) begin
               state_d    = RUN;
               init_idx_d = '0;
            end else begin
               init_idx_d = init_idx_q + IDX_W'(1);
            end
         end
         RUN: begin
            if (flush) begin
               state_d    = INIT;
               init_idx_d = '0;
            end else if (upd_en_s) begin
               bht_d[upd_idx] = upd_next_s;
            end else begin
               bht_d = bht_q;
            end
         end
         default: begin
            state_d    = INIT;
            init_idx_d = '0;
         end
      endcase
   end

   // Write-first bypass: a same-index update is visible to the lookup.
   always_comb begin
      resp_valid_d = 1'b0;
      resp_count_d = 2'b00;
      if (pred_acc_s) begin
         resp_valid_d = 1'b1;
         if (upd_en_s && (upd_idx == pred_idx)) begin
            resp_count_d = upd_next_s;
         end else begin
            resp_count_d = bht_q[pred_idx];
         end
      end else begin
         resp_count_d = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         init_idx_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_count_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         resp_valid_q <= resp_valid_d;
         resp_count_q <= resp_count_d;
      end
   end

   // Table contents are defined only by the init sequence, so no reset here.
   always_ff @(posedge clk) begin
      bht_q <= bht_d;
   end

endmodule

// File: tb/tb_bht_controller.sv
// Directed self-checking bench for bht_controller.
module tb_bht_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       busy;
   logic       pred_valid = 1'b0;
   logic       pred_ready;
   logic [3:0] pred_idx = 4'd0;
   logic       resp_valid;
   logic       resp_taken;
   logic [1:0] resp_count;
   logic       upd_valid = 1'b0;
   logic       upd_ready;
   logic [3:0] upd_idx = 4'd0;
   logic       upd_taken = 1'b0;

   int checks = 0;
   int errors = 0;
   int n;

   bht_controller dut (
      .clk(clk), .rst(rst), .flush(flush), .busy(busy),
      .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_idx(pred_idx),
      .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_count(resp_count),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
      .upd_taken(upd_taken)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // counts samples with busy high, bounded so a stuck INIT still terminates
   task automatic wait_init(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
   endtask

   task automatic lookup(input logic [3:0] idx, input logic [1:0] exp, input string tag);
      pred_valid = 1'b1;
      pred_idx   = idx;
      step();
      pred_valid = 1'b0;
      check({tag, "_valid"}, {7'd0, resp_valid}, 8'd1);
      check({tag, "_count"}, {6'd0, resp_count}, {6'd0, exp});
      check({tag, "_taken"}, {7'd0, resp_taken}, {7'd0, exp[1]});
   endtask

   task automatic update(input logic [3:0] idx, input logic taken);
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_taken = taken;
      step();
      upd_valid = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_up [4];
      logic [1:0] exp_dn [4];
      exp_up = '{2'd2, 2'd3, 2'd3, 2'd3};
      exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0};

      // reset state
      step(); step(); step();
      check("rst_busy", {7'd0, busy}, 8'd1);
      check("rst_pred_ready", {7'd0, pred_ready}, 8'd0);
      check("rst_upd_ready", {7'd0, upd_ready}, 8'd0);
      check("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
      check("rst_resp_count", {6'd0, resp_count}, 8'd0);
      rst = 1'b0;
      wait_init(n);
      check("init_len", 8'(n), 8'd16);
      check("run_pred_ready", {7'd0, pred_ready}, 8'd1);
      check("run_upd_ready", {7'd0, upd_ready}, 8'd1);

      for (int i = 0; i < 16; i++) lookup(4'(i), 2'd1, "init_val");
      step();
      check("idle_resp_valid", {7'd0, resp_valid}, 8'd0);

      // saturating training of idx 5
      for (int i = 0; i < 4; i++) begin
         update(4'd5, 1'b1);
         lookup(4'd5, exp_up[i], "up5");
      end
      for (int i = 0; i < 4; i++) begin
         update(4'd5, 1'b0);
         lookup(4'd5, exp_dn[i], "dn5");
      end

      // simultaneous lookup 7 / update 8, then same-index bypass on 7
      pred_valid = 1'b1; pred_idx = 4'd7;
      upd_valid = 1'b1; upd_idx = 4'd8; upd_taken = 1'b1;
      step();
      pred_valid = 1'b0; upd_valid = 1'b0;
      check("diff_count", {6'd0, resp_count}, 8'd1);
      lookup(4'd8, 2'd2, "diff_upd8");
      pred_valid = 1'b1; pred_idx = 4'd7;
      upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
      step();
      pred_valid = 1'b0; upd_valid = 1'b0;
      check("bypass_valid", {7'd0, resp_valid}, 8'd1);
      check("bypass_count", {6'd0, resp_count}, 8'd2);

      // train idx 3 to strongly-taken, then flush with an in-flight lookup
      update(4'd3, 1'b1);
      update(4'd3, 1'b1);
      lookup(4'd3, 2'd3, "pre_flush3");
      flush = 1'b1;
      pred_valid = 1'b1; pred_idx = 4'd3;
      upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b0;
      step();
      flush = 1'b0; pred_valid = 1'b0;
      check("inflight_valid", {7'd0, resp_valid}, 8'd1);
      check("inflight_count", {6'd0, resp_count}, 8'd3);
      check("flush_pred_ready", {7'd0, pred_ready}, 8'd0);
      check("flush_upd_ready", {7'd0, upd_ready}, 8'd0);
      upd_taken = 1'b1;
      wait_init(n);
      upd_valid = 1'b0;
      check("flush_init_len", 8'(n), 8'd16);
      lookup(4'd3, 2'd1, "post_flush3");

      // flush again, and re-flush at INIT cycle 10
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check("mid_init_busy", {7'd0, busy}, 8'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_init(n);
      check("reflush_init_len", 8'(n), 8'd16);

      // asynchronous reset mid-RUN with a response pending
      update(4'd5, 1'b0);
      pred_valid = 1'b1; pred_idx = 4'd5;
      step();
      pred_valid = 1'b0;
      check("pre_arst_valid", {7'd0, resp_valid}, 8'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", {7'd0, busy}, 8'd1);
      check("arst_resp_valid", {7'd0, resp_valid}, 8'd0);
      check("arst_pred_ready", {7'd0, pred_ready}, 8'd0);
      step();
      rst = 1'b0;
      wait_init(n);
      check("arst_init_len", 8'(n), 8'd16);
      lookup(4'd5, 2'd1, "arst_val5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
